// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for the RV32I-subset core.
// A Moore FSM steps each instruction through fetch, decode, execute,
// memory and writeback. It drives the shared ALU's operand selects and op
// code, and the PC, IR, register-file and memory strobes.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t cur;
  state_t nxt;
  state_t cur_eff;
  state_t dec_target;
  logic   alu_f3_ok;
  logic   zero;
  logic   flags_unused;

  // Branches only look at Z; the remaining flags are carried for future use.
  assign zero         = flags[2];
  assign flags_unused = ^{flags[3], flags[1:0]};
  assign state        = cur;

  // While reset is held, outputs present the FETCH decode of the datapath.
  assign cur_eff = rst_n ? cur : FETCH;

  // funct3 values the ALU path supports: add/sub, slt, or, and.
  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  // Map funct3 (and funct7b5 for R-type only) onto the ALU op encoding.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_dec = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  // Decode-stage dispatch: unsupported op/funct3 combinations return to FETCH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dec_target = FETCH;
    case (op)
      OP_LW, OP_SW: if (funct3 == 3'b010) dec_target = MEMADR;
      OP_R:         if (alu_f3_ok) dec_target = EXECR;
      OP_I:         if (alu_f3_ok) dec_target = EXECI;
      OP_BR:        if (funct3 == 3'b000 || funct3 == 3'b001) dec_target = BRANCH;
      OP_JAL:       dec_target = JAL;
      default:      dec_target = FETCH;
    endcase
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = dec_target;
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BRANCH:   nxt = FETCH;
      JAL:      nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // Moore output decode; write and request strobes are gated off during reset.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (cur_eff)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_SW:   imm_src = 2'b01;
          OP_BR:   imm_src = 2'b10;
          OP_JAL:  imm_src = 2'b11;
          default: imm_src = 2'b00;
        endcase
        illegal = (dec_target == FETCH);
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = alu_dec(funct3, funct7b5);
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_dec(funct3, 1'b0);
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALU_SUB;
        pc_write  = (funct3 == 3'b000) ? zero : ~zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Each instruction is expanded by
// a reference model into its expected per-cycle output trace; the driver
// pushes each cycle's expectation as it applies stimulus, and a monitor on
// the falling edge pops and compares.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] flags;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, mem_req, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .flags(flags), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .mem_req(mem_req), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, adr_src, mem_write, mem_req, ir_write, reg_write;
    logic [1:0] result_src, src_a, src_b, imm_src;
    logic [2:0] alu_op;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic mr;
    obs_t o;
  } step_t;

  typedef enum {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_BAD} kind_t;

  step_t plan[$];
  obs_t  sb[$];
  string sb_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_label;
  obs_t  act, exp_o;
  string exp_name;

  assign act = {state, pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal};

  task automatic check(input string name, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (state got %0d want %0d)", name, a, e, a.st, e.st);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_o    = sb.pop_front();
      exp_name = sb_name.pop_front();
      check(exp_name, act, exp_o);
    end
  end

  // ---------------- reference model ----------------
  function automatic obs_t blank(input logic [3:0] s);
    obs_t o;
    o    = '0;
    o.st = s;
    return o;
  endfunction

  function automatic kind_t classify(input logic [6:0] o, input logic [2:0] f3);
    bit alu_ok;
    alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    case (o)
      7'b0000011: return (f3 == 3'd2) ? K_LW : K_BAD;
      7'b0100011: return (f3 == 3'd2) ? K_SW : K_BAD;
      7'b0110011: return alu_ok ? K_R : K_BAD;
      7'b0010011: return alu_ok ? K_I : K_BAD;
      7'b1100011: return (f3 <= 3'd1) ? K_BR : K_BAD;
      7'b1101111: return K_JAL;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic add(input logic mr, input obs_t o);
    step_t s;
    s.rst = 1'b1;
    s.mr  = mr;
    s.o   = o;
    plan.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand the instruction currently on the inputs into its cycle trace.
  task automatic build(input int wf, input int wm);
    kind_t k;
    obs_t  o;
    k = classify(op, funct3);
    for (int i = 0; i <= wf; i++) begin
      o = blank(4'd0);
      o.mem_req = 1'b1; o.src_b = 2'b10; o.result_src = 2'b10;
      o.ir_write = (i == wf); o.pc_write = (i == wf);
      add(i == wf, o);
    end
    o = blank(4'd1);
    o.src_a = 2'b01; o.src_b = 2'b01; o.imm_src = imm_of(op);
    o.illegal = (k == K_BAD);
    add(rnd_bit(), o);
    case (k)
      K_LW, K_SW: begin
        o = blank(4'd2);
        o.src_a = 2'b10; o.src_b = 2'b01; o.imm_src = (k == K_SW) ? 2'b01 : 2'b00;
        add(rnd_bit(), o);
        for (int i = 0; i <= wm; i++) begin
          o = blank((k == K_LW) ? 4'd3 : 4'd5);
          o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = (k == K_SW);
          add(i == wm, o);
        end
        if (k == K_LW) begin
          o = blank(4'd4);
          o.result_src = 2'b01; o.reg_write = 1'b1;
          add(rnd_bit(), o);
        end
      end
      K_R, K_I: begin
        o = blank((k == K_R) ? 4'd6 : 4'd7);
        o.src_a = 2'b10; o.src_b = (k == K_R) ? 2'b00 : 2'b01;
        o.alu_op = alu_of(funct3, funct7b5, k == K_R);
        add(rnd_bit(), o);
        o = blank(4'd8); o.reg_write = 1'b1;
        add(rnd_bit(), o);
      end
      K_BR: begin
        o = blank(4'd9);
        o.src_a = 2'b10; o.alu_op = 3'b001;
        o.pc_write = (funct3 == 3'd0) ? flags[2] : ~flags[2];
        add(rnd_bit(), o);
      end
      K_JAL: begin
        o = blank(4'd10);
        o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1;
        add(rnd_bit(), o);
        o = blank(4'd8); o.reg_write = 1'b1;
        add(rnd_bit(), o);
      end
      default: ;
    endcase
  endtask

  // Drive the plan one cycle per step, publishing each expectation.
  task automatic run_plan();
    int c;
    c = 0;
    while (plan.size() > 0) begin
      step_t s;
      s = plan.pop_front();
      rst_n     = s.rst;
      mem_ready = s.mr;
      sb.push_back(s.o);
      sb_name.push_back($sformatf("%s c%0d", cur_label, c));
      c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl, input string lbl);
    op = o; funct3 = f3; funct7b5 = f7; flags = fl; cur_label = lbl;
  endtask

  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [3:0] fl, input int wf, input int wm, input string lbl);
    set_instr(o, f3, f7, fl, lbl);
    build(wf, wm);
    run_plan();
  endtask

  initial begin
    step_t r;
    obs_t  ro;
    rst_n = 1'b0; mem_ready = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0, 4'd0, "init");
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting in MEMWRITE: sw whose write handshake is cut off.
    set_instr(7'b0100011, 3'd2, 1'b0, 4'd0, "rst_sw");
    build(0, 1);
    void'(plan.pop_back());
    ro = blank(4'd5);
    ro.src_b = 2'b10; ro.result_src = 2'b10;
    r.rst = 1'b0; r.mr = 1'b0; r.o = ro;
    plan.push_back(r);
    ro.st = 4'd0; r.o = ro;
    plan.push_back(r);
    run_plan();

    do_instr(7'b0110011, 3'd0, 1'b1, 4'd0, 0, 0, "r_sub");
    do_instr(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 2, "lw_w2");
    do_instr(7'b1100011, 3'd0, 1'b0, 4'b0100, 0, 0, "beq_z");
    do_instr(7'b1100011, 3'd1, 1'b0, 4'b0100, 0, 0, "bne_z");
    do_instr(7'b0010011, 3'd2, 1'b1, 4'd0, 0, 0, "slti");
    do_instr(7'b0010011, 3'd6, 1'b0, 4'd0, 0, 0, "ori");
    do_instr(7'b0000000, 3'd0, 1'b0, 4'd0, 0, 0, "ill_op");
    do_instr(7'b0110011, 3'd1, 1'b0, 4'd0, 0, 0, "ill_f3");
    do_instr(7'b1101111, 3'd5, 1'b1, 4'd0, 1, 0, "jal");
    do_instr(7'b0100011, 3'd2, 1'b0, 4'd0, 2, 2, "sw_w2");

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      bool_legal: begin end
      case ($urandom_range(0, 7))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        6: o = 7'b0110011;
        default: o = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case (o)
          7'b0000011, 7'b0100011: f3 = 3'd2;
          7'b1100011:             f3 = 3'($urandom_range(0, 1));
          7'b0110011, 7'b0010011: begin
            case ($urandom_range(0, 3))
              0: f3 = 3'd0;
              1: f3 = 3'd2;
              2: f3 = 3'd6;
              default: f3 = 3'd7;
            endcase
          end
          default: ;
        endcase
      end
      do_instr(o, f3, rnd_bit(), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
               $sformatf("rnd%0d", n));
    end

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the RV32I-subset core: a Moore FSM that sequences fetch, decode, execute, memory and writeback across several cycles and drives the shared ALU. It sits directly upstream of the ALU and produces its 3-bit op (000 add, 001 sub, 010 and, 011 or, 101 slt). It consumes the ALU flags {N,Z,C,V} for branch resolution and waits on a single-port memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- flags  in  4  ALU flags: [0]=V, [1]=C, [2]=Z, [3]=N
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- mem_req  out  1  memory access request
- ir_write  out  1  IR and old-PC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=old PC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_op  out  3  ALU operation (encoding above)
- illegal  out  1  one-cycle pulse on unsupported instruction
- state  out  4  current state (for verification)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10. Codes 11–15 are unreachable; if entered, go to FETCH.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=000, result_src=10. ir_write and pc_write are 1 only when mem_ready=1. Hold in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE: a=01, b=01, alu_op=000 (branch/jal target into ALUOut). imm_src follows op.
  - lw (0000011) and sw (0100011) with funct3=010 -> MEMADR.
  - R (0110011) -> EXECR.
  - I-ALU (0010011) -> EXECI.
  - branch (1100011) with funct3 000 (beq) or 001 (bne) -> BRANCH.
  - jal (1101111) -> JAL.
  - Any other op, or a funct3 not listed -> illegal=1 for this cycle, then FETCH.
- MEMADR: a=10, b=01, alu_op=000, imm_src=I for lw and S for sw. Go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then FETCH.
- EXECR / EXECI: a=10, b=00 (R) or 01 (I). Go to ALUWB.
  - alu_op from funct3: 000 -> add; for R only, funct7b5=1 selects sub. 010 -> 101 (slt). 110 -> 011 (or). 111 -> 010 (and).
  - I-type ignores funct7b5.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BRANCH: a=10, b=00, alu_op=001, result_src=00.
  - pc_write = flags[2] for beq, ~flags[2] for bne; flags are sampled combinationally in this cycle.
  - Go to FETCH.
- JAL: a=01, b=10, alu_op=000, result_src=00, pc_write=1. Go to ALUWB, which writes rd = old PC+4.
- Any output not listed for a state is 0.

## Timing
- rst_n sampled at the rising edge; it is 0 -> state=FETCH on the next cycle, from any state, including mid-wait.
- While rst_n=0, pc_write, ir_write, reg_write, mem_write, mem_req and illegal are forced to 0 combinationally. All other outputs take the FETCH values.
- All outputs are functions of state only, plus mem_ready (FETCH), flags/funct3 (BRANCH) and op/funct3 (DECODE, MEMADR, EXEC*). There are no registered outputs beyond state.
- Cycle counts with zero wait states:
  - lw: 5
  - sw: 4
  - R, I: 4
  - beq/bne: 3
  - jal: 4
  - illegal: 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay constant during the wait.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while in MEMWRITE with mem_ready=0 -> state=0 next edge, mem_write=0 during reset.
- R sub: op=0110011, funct3=000, funct7b5=1, mem_ready=1 -> states 0,1,6,8,0; alu_op=001 in EXECR; reg_write=1 only in ALUWB.
- lw with 2 wait states in MEMREAD -> states 0,1,2,3,3,3,4,0; adr_src=1 throughout MEMREAD; result_src=01 with reg_write=1 in MEMWB.
- beq with flags=4'b0100, then bne with the same flags -> beq: pc_write=1 in BRANCH; bne: pc_write=0; both take 3 cycles.
- I slti: op=0010011, funct3=010, funct7b5=1 -> alu_op=101 in EXECI (funct7b5 ignored). I ori: funct3=110 -> alu_op=011.
- Illegal: op=0000000, and separately op=0110011 with funct3=001 -> illegal=1 for exactly one cycle in DECODE, state returns to 0, and no write strobe is asserted.
